div_ctrl: RTL and testbench

- EX-stage sequencer for the shared 32-bit iterative divider.
- Accepts RV32M DIV/DIVU/REM/REMU requests from EX and stalls the pipeline while the divider is busy.
- Drives the divider start/cancel/signed/rem handshake and returns the result on a registered writeback port.
- Fast-paths divide-by-zero, signed overflow and repeats of the last result (exact-match cache) without occupying the divider.

---
 rtl/div_ctrl.sv | 153 +++++++++++++++
 tb/tb_div_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_ctrl.sv
// EX-stage sequencer for the shared 32-bit iterative divider. Answers divide-by-zero,
// signed overflow and exact repeats of the last divider result without starting the divider.
module div_ctrl #(
    parameter bit CACHE_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    input  logic [4:0]  rd_addr_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        wb_valid_o,
    output logic [31:0] wb_data_o,
    output logic [4:0]  wb_addr_o,
    output logic        div_start_o,
    output logic        div_cancel_o,
    output logic        div_signed_o,
    output logic        div_rem_o,
    output logic [31:0] div_op1_o,
    output logic [31:0] div_op2_o,
    input  logic [31:0] div_result_i,
    input  logic        div_ready_i
);
    typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

    state_t      state;
    state_t      state_next;
    logic        cache_valid;
    logic [65:0] cache_key;
    logic [31:0] cache_data;
    logic [4:0]  rd_q;
    logic        div_zero;
    logic        overflow;
    logic        hit;
    logic        fast;
    logic [31:0] fast_data;
    logic        issue_fast;
    logic        issue_slow;
    logic        complete;
    logic        abort;

    // op_i[0] = 0 selects the signed forms, op_i[1] = 1 selects the remainder forms
    assign div_zero = (rs2_i == 32'd0);
    assign overflow = !op_i[0] && (rs1_i == 32'h8000_0000) && (rs2_i == 32'hFFFF_FFFF);
    assign hit      = CACHE_EN && cache_valid && (cache_key == {op_i, rs1_i, rs2_i});
    assign fast     = div_zero || overflow || hit;

    always_comb begin
        fast_data = cache_data;
        if (div_zero) begin
            fast_data = op_i[1] ? rs1_i : 32'hFFFF_FFFF;
        end else if (overflow) begin
            fast_data = op_i[1] ? 32'd0 : 32'h8000_0000;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        stall_o      = 1'b0;
        div_cancel_o = 1'b0;
        issue_fast   = 1'b0;
        issue_slow   = 1'b0;
        complete     = 1'b0;
        abort        = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid_i && fast) begin
                    issue_fast = !flush_i;
                end else if (req_valid_i) begin
                    stall_o = 1'b1;
                    if (!flush_i) begin
                        issue_slow = 1'b1;
                        state_next = BUSY;
                    end
                end
            end
            // One cycle with start low so the divider can return to its free state
            DRAIN: begin
                state_next = IDLE;
                if (req_valid_i && fast) begin
                    issue_fast = !flush_i;
                end else if (req_valid_i) begin
                    stall_o = 1'b1;
                end
            end
            BUSY: begin
                stall_o = !div_ready_i;
                if (flush_i) begin
                    div_cancel_o = 1'b1;
                    abort        = 1'b1;
                    state_next   = DRAIN;
                end else if (div_ready_i) begin
                    complete   = 1'b1;
                    state_next = DRAIN;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid_o   <= 1'b0;
            wb_data_o    <= 32'd0;
            wb_addr_o    <= 5'd0;
            div_start_o  <= 1'b0;
            div_signed_o <= 1'b0;
            div_rem_o    <= 1'b0;
            div_op1_o    <= 32'd0;
            div_op2_o    <= 32'd0;
            rd_q         <= 5'd0;
            cache_valid  <= 1'b0;
            cache_key    <= 66'd0;
            cache_data   <= 32'd0;
        end else begin
            wb_valid_o <= issue_fast || complete;
            if (issue_fast) begin
                wb_data_o <= fast_data;
                wb_addr_o <= rd_addr_i;
            end
            if (issue_slow) begin
                div_start_o  <= 1'b1;
                div_signed_o <= !op_i[0];
                div_rem_o    <= op_i[1];
                div_op1_o    <= rs1_i;
                div_op2_o    <= rs2_i;
                rd_q         <= rd_addr_i;
            end
            if (complete) begin
                wb_data_o   <= div_result_i;
                wb_addr_o   <= rd_q;
                div_start_o <= 1'b0;
                cache_valid <= 1'b1;
                cache_key   <= {div_rem_o, !div_signed_o, div_op1_o, div_op2_o};
                cache_data  <= div_result_i;
            end
            if (abort) begin
                div_start_o <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl: a cached (CACHE_EN=1) and an uncached instance, each served by a
// behavioural divider with adjustable latency, checked against a plain arithmetic model.
module tb_div_ctrl;
    localparam logic [1:0] DIV = 2'd0, DIVU = 2'd1, REM = 2'd2, REMU = 2'd3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid [2];
    logic [1:0]  op;
    logic [31:0] rs1, rs2;
    logic [4:0]  rd;
    logic        flush;
    logic        stall [2], wb_valid [2], div_start [2], div_cancel [2];
    logic        div_signed [2], div_rem [2], div_ready [2];
    logic [31:0] wb_data [2], div_op1 [2], div_op2 [2], div_result [2];
    logic [4:0]  wb_addr [2];

    int          n_checks = 0;
    int          n_fail = 0;
    int          lat = 4;
    int          cnt [2];
    bit          m_valid [2];
    logic [65:0] m_key [2];
    logic [1:0]  last_op [2];
    logic [31:0] last_a [2], last_b [2];

    int          obs_stalls;
    bit          obs_started, obs_wb, obs_timeout;
    logic        obs_signed, obs_rem;
    logic [31:0] obs_op1, obs_op2, obs_data;
    logic [4:0]  obs_addr;

    div_ctrl #(.CACHE_EN(1'b1)) u_cached (
        .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid[0]), .op_i(op), .rs1_i(rs1),
        .rs2_i(rs2), .rd_addr_i(rd), .flush_i(flush), .stall_o(stall[0]),
        .wb_valid_o(wb_valid[0]), .wb_data_o(wb_data[0]), .wb_addr_o(wb_addr[0]),
        .div_start_o(div_start[0]), .div_cancel_o(div_cancel[0]), .div_signed_o(div_signed[0]),
        .div_rem_o(div_rem[0]), .div_op1_o(div_op1[0]), .div_op2_o(div_op2[0]),
        .div_result_i(div_result[0]), .div_ready_i(div_ready[0])
    );

    div_ctrl #(.CACHE_EN(1'b0)) u_uncached (
        .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid[1]), .op_i(op), .rs1_i(rs1),
        .rs2_i(rs2), .rd_addr_i(rd), .flush_i(flush), .stall_o(stall[1]),
        .wb_valid_o(wb_valid[1]), .wb_data_o(wb_data[1]), .wb_addr_o(wb_addr[1]),
        .div_start_o(div_start[1]), .div_cancel_o(div_cancel[1]), .div_signed_o(div_signed[1]),
        .div_rem_o(div_rem[1]), .div_op1_o(div_op1[1]), .div_op2_o(div_op2[1]),
        .div_result_i(div_result[1]), .div_ready_i(div_ready[1])
    );

    always #5 clk = ~clk;

    // RV32M result rules in plain arithmetic
    function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
        if (!o[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
            sa = $signed(a);
            sb = $signed(b);
            return o[1] ? 32'(sa % sb) : 32'(sa / sb);
        end
        return o[1] ? (a % b) : (a / b);
    endfunction

    function automatic bit model_fast(input int u, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        bit special;
        special = (b == 32'd0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        return special || (u == 0 && m_valid[u] && m_key[u] == {o, a, b});
    endfunction

    function automatic void note_done(input int u, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        if (!model_fast(u, o, a, b)) begin
            m_valid[u] = 1'b1;
            m_key[u]   = {o, a, b};
        end
    endfunction

    // Behavioural divider: result valid 'lat' cycles after start is seen high
    always @(posedge clk or negedge rst_n) begin
        #1;
        for (int g = 0; g < 2; g++) begin
            if (!rst_n || !div_start[g]) begin
                cnt[g] = 0;
                div_ready[g] = 1'b0;
                div_result[g] = 32'hDEAD_BEEF;
            end else begin
                cnt[g]++;
                if (cnt[g] == 1) begin
                    n_checks++; if (div_op2[g] === 32'd0) begin n_fail++; $display("[TB] FAIL nonzero_divisor inst=%0d got=%h required nonzero", g, div_op2[g]); end
                end
                div_ready[g] = (cnt[g] == lat);
                div_result[g] = div_ready[g] ? ref_result({div_rem[g], ~div_signed[g]}, div_op1[g], div_op2[g]) : 32'hDEAD_BEEF;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Presents one request until it leaves EX and records what the DUT did with it
    task automatic issue_op(input int u, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic [4:0] r);
        int n;
        n = 0;
        obs_stalls = 0; obs_started = 0; obs_signed = 0; obs_rem = 0; obs_op1 = 0; obs_op2 = 0;
        op = o; rs1 = a; rs2 = b; rd = r; req_valid[u] = 1'b1;
        #1;
        while (stall[u] === 1'b1 && n < 200) begin
            obs_stalls++;
            n++;
            step();
            if (div_start[u] === 1'b1 && !obs_started) begin
                obs_started = 1'b1;
                obs_signed = div_signed[u]; obs_rem = div_rem[u];
                obs_op1 = div_op1[u]; obs_op2 = div_op2[u];
            end
        end
        obs_timeout = (n >= 200);
        step();
        req_valid[u] = 1'b0;
        if (div_start[u] === 1'b1) obs_started = 1'b1;
        obs_wb = wb_valid[u]; obs_data = wb_data[u]; obs_addr = wb_addr[u];
    endtask

    task automatic test_reset();
        for (int u = 0; u < 2; u++) begin
            n_checks++; if ({stall[u], wb_valid[u], wb_data[u], wb_addr[u], div_start[u], div_cancel[u], div_signed[u], div_rem[u], div_op1[u], div_op2[u]} !== '0) begin n_fail++; $display("[TB] FAIL reset_outputs inst=%0d got=%h required 0", u, {stall[u], wb_valid[u], wb_data[u], wb_addr[u], div_start[u], div_cancel[u], div_signed[u], div_rem[u], div_op1[u], div_op2[u]}); end
        end
    endtask

    task automatic test_div_basic();
        lat = 4;
        issue_op(0, DIV, 32'd100, 32'd7, 5'd5);
        n_checks++; if (obs_timeout) begin n_fail++; $display("[TB] FAIL basic_timeout got stall stuck required release"); end
        n_checks++; if (obs_stalls != 4) begin n_fail++; $display("[TB] FAIL basic_stall_cycles got=%0d required 4", obs_stalls); end
        n_checks++; if ({obs_started, obs_signed, obs_rem} !== 3'b110) begin n_fail++; $display("[TB] FAIL basic_ctrl got=%b required 110", {obs_started, obs_signed, obs_rem}); end
        n_checks++; if ({obs_op1, obs_op2} !== {32'd100, 32'd7}) begin n_fail++; $display("[TB] FAIL basic_operands got=%h/%h required 64/7", obs_op1, obs_op2); end
        n_checks++; if ({obs_wb, obs_data, obs_addr} !== {1'b1, 32'd14, 5'd5}) begin n_fail++; $display("[TB] FAIL basic_wb got v=%b d=%h a=%0d required v=1 d=e a=5", obs_wb, obs_data, obs_addr); end
        note_done(0, DIV, 32'd100, 32'd7);
        issue_op(0, DIV, 32'd100, 32'd6, 5'd6);
        n_checks++; if (obs_stalls != 5) begin n_fail++; $display("[TB] FAIL drain_stall_cycles got=%0d required 5", obs_stalls); end
        n_checks++; if ({obs_wb, obs_data, obs_addr} !== {1'b1, 32'd16, 5'd6}) begin n_fail++; $display("[TB] FAIL drain_wb got v=%b d=%h a=%0d required v=1 d=10 a=6", obs_wb, obs_data, obs_addr); end
        note_done(0, DIV, 32'd100, 32'd6);
        step();
        n_checks++; if ({wb_valid[0], div_start[0]} !== 2'b00) begin n_fail++; $display("[TB] FAIL wb_pulse_width got=%b required 00", {wb_valid[0], div_start[0]}); end
    endtask

    task automatic test_signedness();
        lat = int'($urandom_range(1, 6));
        issue_op(0, REM, 32'hFFFF_FFF9, 32'd2, 5'd7);
        n_checks++; if ({obs_started, obs_signed, obs_rem} !== 3'b111) begin n_fail++; $display("[TB] FAIL rem_signed_ctrl got=%b required 111", {obs_started, obs_signed, obs_rem}); end
        n_checks++; if (obs_data !== 32'hFFFF_FFFF) begin n_fail++; $display("[TB] FAIL rem_signed_data got=%h required ffffffff", obs_data); end
        note_done(0, REM, 32'hFFFF_FFF9, 32'd2);
        issue_op(0, DIVU, 32'hFFFF_FFF9, 32'd2, 5'd8);
        n_checks++; if ({obs_started, obs_signed, obs_rem} !== 3'b100) begin n_fail++; $display("[TB] FAIL divu_ctrl got=%b required 100", {obs_started, obs_signed, obs_rem}); end
        n_checks++; if (obs_data !== 32'h7FFF_FFFC) begin n_fail++; $display("[TB] FAIL divu_data got=%h required 7ffffffc", obs_data); end
        note_done(0, DIVU, 32'hFFFF_FFF9, 32'd2);
    endtask

    task automatic test_div_zero();
        issue_op(0, DIVU, 32'h1234, 32'd0, 5'd11);
        n_checks++; if (obs_stalls != 0 || obs_started) begin n_fail++; $display("[TB] FAIL divz_no_divider got stalls=%0d start=%b required 0/0", obs_stalls, obs_started); end
        n_checks++; if ({obs_wb, obs_data, obs_addr} !== {1'b1, 32'hFFFF_FFFF, 5'd11}) begin n_fail++; $display("[TB] FAIL divz_wb got v=%b d=%h a=%0d required v=1 d=ffffffff a=11", obs_wb, obs_data, obs_addr); end
        issue_op(0, REMU, 32'h1234, 32'd0, 5'd12);
        n_checks++; if (obs_stalls != 0 || obs_started) begin n_fail++; $display("[TB] FAIL remz_no_divider got stalls=%0d start=%b required 0/0", obs_stalls, obs_started); end
        n_checks++; if ({obs_wb, obs_data} !== {1'b1, 32'h1234}) begin n_fail++; $display("[TB] FAIL remz_wb got v=%b d=%h required v=1 d=1234", obs_wb, obs_data); end
    endtask

    task automatic test_overflow();
        issue_op(0, DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13);
        n_checks++; if (obs_stalls != 0 || obs_started) begin n_fail++; $display("[TB] FAIL ovf_div_fast got stalls=%0d start=%b required 0/0", obs_stalls, obs_started); end
        n_checks++; if (obs_data !== 32'h8000_0000) begin n_fail++; $display("[TB] FAIL ovf_div_data got=%h required 80000000", obs_data); end
        issue_op(0, REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13);
        n_checks++; if (obs_started || obs_data !== 32'd0 || !obs_wb) begin n_fail++; $display("[TB] FAIL ovf_rem got start=%b d=%h v=%b required 0/0/1", obs_started, obs_data, obs_wb); end
        lat = int'($urandom_range(1, 6));
        issue_op(0, DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13);
        n_checks++; if ({obs_started, obs_signed} !== 2'b10 || obs_data !== 32'd0) begin n_fail++; $display("[TB] FAIL ovf_divu got start/signed=%b d=%h required 10/0", {obs_started, obs_signed}, obs_data); end
        note_done(0, DIVU, 32'h8000_0000, 32'hFFFF_FFFF);
    endtask

    task automatic test_flush();
        int n;
        lat = 20;
        op = DIV; rs1 = 32'd100; rs2 = 32'd7; rd = 5'd3; req_valid[0] = 1'b1;
        #1;
        n_checks++; if (stall[0] !== 1'b1) begin n_fail++; $display("[TB] FAIL flush_stall_idle got=%b required 1", stall[0]); end
        repeat (5) step();
        n_checks++; if (div_start[0] !== 1'b1) begin n_fail++; $display("[TB] FAIL flush_busy_start got=%b required 1", div_start[0]); end
        flush = 1'b1;
        #1;
        n_checks++; if (div_cancel[0] !== 1'b1) begin n_fail++; $display("[TB] FAIL flush_cancel got=%b required 1", div_cancel[0]); end
        step();
        flush = 1'b0; req_valid[0] = 1'b0;
        #1;
        n_checks++; if ({div_cancel[0], div_start[0], wb_valid[0]} !== 3'b000) begin n_fail++; $display("[TB] FAIL flush_after got cancel/start/wb=%b required 000", {div_cancel[0], div_start[0], wb_valid[0]}); end
        step();
        n_checks++; if (wb_valid[0] !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_no_wb got=%b required 0", wb_valid[0]); end
        lat = 3;
        issue_op(0, DIV, 32'd100, 32'd7, 5'd4);
        n_checks++; if (!obs_started || obs_timeout || {obs_wb, obs_data, obs_addr} !== {1'b1, 32'd14, 5'd4}) begin n_fail++; $display("[TB] FAIL reissue got start=%b v=%b d=%h a=%0d required 1/1/e/4", obs_started, obs_wb, obs_data, obs_addr); end
        note_done(0, DIV, 32'd100, 32'd7);
        lat = 4;
        op = DIV; rs1 = 32'd200; rs2 = 32'd7; rd = 5'd9; req_valid[0] = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (div_ready[0] !== 1'b1 && n < 50);
        n_checks++; if (n >= 50) begin n_fail++; $display("[TB] FAIL ready_timeout got no ready required ready within 50 cycles"); end
        flush = 1'b1;
        #1;
        n_checks++; if (div_cancel[0] !== 1'b1) begin n_fail++; $display("[TB] FAIL flush_ready_cancel got=%b required 1", div_cancel[0]); end
        step();
        flush = 1'b0; req_valid[0] = 1'b0;
        n_checks++; if ({wb_valid[0], div_start[0]} !== 2'b00) begin n_fail++; $display("[TB] FAIL flush_ready_no_wb got wb/start=%b required 00", {wb_valid[0], div_start[0]}); end
        step();
        n_checks++; if (wb_valid[0] !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_ready_late_wb got=%b required 0", wb_valid[0]); end
    endtask

    task automatic test_cache();
        issue_op(0, DIV, 32'd100, 32'd7, 5'd10);
        n_checks++; if (obs_stalls != 0 || obs_started) begin n_fail++; $display("[TB] FAIL cache_hit_fast got stalls=%0d start=%b required 0/0", obs_stalls, obs_started); end
        n_checks++; if ({obs_wb, obs_data, obs_addr} !== {1'b1, 32'd14, 5'd10}) begin n_fail++; $display("[TB] FAIL cache_hit_wb got v=%b d=%h a=%0d required v=1 d=e a=10", obs_wb, obs_data, obs_addr); end
        lat = 2;
        issue_op(0, REM, 32'd100, 32'd7, 5'd14);
        n_checks++; if (!obs_started || obs_data !== 32'd2) begin n_fail++; $display("[TB] FAIL cache_op_miss got start=%b d=%h required 1/2", obs_started, obs_data); end
        note_done(0, REM, 32'd100, 32'd7);
        lat = 3;
        issue_op(0, DIV, 32'd200, 32'd7, 5'd15);
        n_checks++; if (!obs_started || obs_data !== 32'd28) begin n_fail++; $display("[TB] FAIL flushed_not_cached got start=%b d=%h required 1/1c", obs_started, obs_data); end
        note_done(0, DIV, 32'd200, 32'd7);
        for (int k = 0; k < 2; k++) begin
            issue_op(1, DIV, 32'd100, 32'd7, 5'd20);
            n_checks++; if (!obs_started || obs_data !== 32'd14 || !obs_wb) begin n_fail++; $display("[TB] FAIL nocache_div pass=%0d got start=%b v=%b d=%h required 1/1/e", k, obs_started, obs_wb, obs_data); end
        end
    endtask

    task automatic test_reset_mid_busy();
        lat = 30;
        op = DIV; rs1 = 32'd9; rs2 = 32'd2; rd = 5'd16; req_valid[0] = 1'b1;
        repeat (3) step();
        n_checks++; if (div_start[0] !== 1'b1) begin n_fail++; $display("[TB] FAIL midrst_busy got start=%b required 1", div_start[0]); end
        req_valid[0] = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        m_valid[0] = 1'b0; m_valid[1] = 1'b0;
        n_checks++; if ({stall[0], wb_valid[0], wb_data[0], wb_addr[0], div_start[0], div_cancel[0], div_signed[0], div_rem[0], div_op1[0], div_op2[0]} !== '0) begin n_fail++; $display("[TB] FAIL midrst_outputs got=%h required 0", {stall[0], wb_valid[0], wb_data[0], wb_addr[0], div_start[0], div_cancel[0], div_signed[0], div_rem[0], div_op1[0], div_op2[0]}); end
        #1 rst_n = 1'b1;
        step();
        n_checks++; if ({wb_valid[0], div_start[0]} !== 2'b00) begin n_fail++; $display("[TB] FAIL midrst_no_wb got wb/start=%b required 00", {wb_valid[0], div_start[0]}); end
        lat = 3;
        issue_op(0, DIV, 32'd100, 32'd7, 5'd17);
        n_checks++; if (!obs_started || {obs_wb, obs_data, obs_addr} !== {1'b1, 32'd14, 5'd17}) begin n_fail++; $display("[TB] FAIL midrst_after got start=%b v=%b d=%h a=%0d required 1/1/e/17", obs_started, obs_wb, obs_data, obs_addr); end
        note_done(0, DIV, 32'd100, 32'd7);
    endtask

    task automatic test_random();
        int u, sel;
        logic [1:0]  o;
        logic [31:0] a, b, exp;
        logic [4:0]  r;
        bit          f;
        for (int i = 0; i < 40; i++) begin
            u = int'($urandom_range(0, 1));
            sel = int'($urandom_range(0, 9));
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            r = 5'($urandom);
            if (sel == 0) b = 32'd0;
            else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (sel <= 3) begin o = last_op[u]; a = last_a[u]; b = last_b[u]; end
            lat = int'($urandom_range(1, 6));
            f = model_fast(u, o, a, b);
            exp = ref_result(o, a, b);
            issue_op(u, o, a, b, r);
            n_checks++; if (obs_timeout || {obs_wb, obs_data, obs_addr} !== {1'b1, exp, r}) begin n_fail++; $display("[TB] FAIL rand_wb i=%0d inst=%0d op=%0d %h/%h got v=%b d=%h a=%0d required v=1 d=%h a=%0d", i, u, o, a, b, obs_wb, obs_data, obs_addr, exp, r); end
            n_checks++; if (obs_started !== !f) begin n_fail++; $display("[TB] FAIL rand_path i=%0d inst=%0d got start=%b required %b", i, u, obs_started, !f); end
            if (f) begin
                n_checks++; if (obs_stalls != 0) begin n_fail++; $display("[TB] FAIL rand_fast_stall i=%0d got=%0d required 0", i, obs_stalls); end
            end else begin
                n_checks++; if ({obs_op1, obs_op2, obs_signed, obs_rem} !== {a, b, ~o[0], o[1]}) begin n_fail++; $display("[TB] FAIL rand_latch i=%0d got=%h/%h s=%b r=%b required %h/%h s=%b r=%b", i, obs_op1, obs_op2, obs_signed, obs_rem, a, b, ~o[0], o[1]); end
                n_checks++; if (obs_stalls < lat || obs_stalls > lat + 1) begin n_fail++; $display("[TB] FAIL rand_stall i=%0d got=%0d required %0d..%0d", i, obs_stalls, lat, lat + 1); end
            end
            note_done(u, o, a, b);
            last_op[u] = o; last_a[u] = a; last_b[u] = b;
        end
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog got no finish required finish before 400000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        req_valid[0] = 1'b0; req_valid[1] = 1'b0;
        op = DIV; rs1 = 32'd0; rs2 = 32'd0; rd = 5'd0; flush = 1'b0;
        m_valid[0] = 1'b0; m_valid[1] = 1'b0;
        for (int u = 0; u < 2; u++) begin
            last_op[u] = DIV; last_a[u] = 32'd100; last_b[u] = 32'd7;
        end
        #3;
        test_reset();
        rst_n = 1'b1;
        step();
        test_div_basic();
        test_signedness();
        test_div_zero();
        test_overflow();
        test_flush();
        test_cache();
        test_reset_mid_busy();
        test_random();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
